// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the serial pattern generator.
// Holds the FSM state type, default frame parameters and the PRBS7 step function.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam logic [7:0]  DEF_PATTERN    = 8'hA5;
    localparam int unsigned DEF_GAP_CYCLES = 2;

    localparam logic [6:0]  PRBS7_SEED   = 7'h7F;
    localparam int unsigned PRBS7_TAP_HI = 6;
    localparam int unsigned PRBS7_TAP_LO = 5;

    // x^7+x^6+1 Fibonacci step: returns {output/feedback bit, next state}.
    function automatic logic [7:0] prbs7_step(input logic [6:0] i_state);
        logic w_fb;
        w_fb = i_state[PRBS7_TAP_HI] ^ i_state[PRBS7_TAP_LO];
        return {w_fb, i_state[5:0], w_fb};
    endfunction

endpackage

// File: rtl/piso_shiftreg.sv
// Parallel-in/serial-out shift register, MSB first, zeros shifted in at the LSB.
// The serial output is the register MSB, so it comes straight from a flop.
module piso_shiftreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_serial
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end else if (i_clear) begin
            r_data <= '0;
        end
    end

    assign o_serial = r_data[WIDTH-1];

endmodule

// File: rtl/shiftreg_pattern_top.sv
// Serial frame generator: shifts a WIDTH-bit word out MSB first with ENdin, then idles GAP_CYCLES.
// Optional macro SHIFTREG_PRBS_PATTERN_EN replaces PATTERN with successive PRBS7 words.
module shiftreg_pattern_top
    import shiftreg_pkg::*;
#(
    parameter int unsigned      WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN    = WIDTH'(DEF_PATTERN),
    parameter int unsigned      GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic CLK,
    input  logic RST_N,
    output logic generated_signal,
    output logic ENdin
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES);
    localparam bit               HAS_GAP  = (GAP_CYCLES != 0);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [7:0]       r_gap_cnt;
    logic [7:0]       w_gap_cnt_nxt;
    logic             r_en;
    logic             w_en_nxt;
    logic             w_load;
    logic             w_shift;
    logic             w_clear;
    logic [WIDTH-1:0] w_load_word;
    logic             w_serial;

`ifdef SHIFTREG_PRBS_PATTERN_EN
    logic [6:0]       r_lfsr;
    logic [6:0]       w_lfsr_nxt;
    logic [WIDTH-1:0] w_prbs_word;

    // Run WIDTH LFSR steps ahead; the first step's bit lands in the word MSB.
    always_comb begin
        logic [6:0] w_s;
        logic [7:0] w_st;
        w_s         = r_lfsr;
        w_st        = '0;
        w_prbs_word = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_st        = prbs7_step(w_s);
            w_prbs_word = {w_prbs_word[WIDTH-2:0], w_st[7]};
            w_s         = w_st[6:0];
        end
        w_lfsr_nxt = w_s;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_lfsr <= PRBS7_SEED;
        end else if (w_load) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign w_load_word = w_prbs_word;
`else
    assign w_load_word = PATTERN;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= LOAD;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_en      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_en      <= w_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_en_nxt      = r_en;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        w_clear       = 1'b0;

        case (r_state)
            LOAD: begin
                w_load        = 1'b1;
                w_en_nxt      = 1'b1;
                w_bit_cnt_nxt = CNT_ONE;
                w_gap_cnt_nxt = '0;
                w_state_nxt   = SHIFT;
            end
            SHIFT: begin
                if (r_bit_cnt == CNT_LAST) begin
                    // Without a gap the reload happens here so frames run back to back.
                    if (HAS_GAP) begin
                        w_clear       = 1'b1;
                        w_en_nxt      = 1'b0;
                        w_bit_cnt_nxt = '0;
                        w_gap_cnt_nxt = 8'd1;
                        w_state_nxt   = GAP;
                    end else begin
                        w_load        = 1'b1;
                        w_en_nxt      = 1'b1;
                        w_bit_cnt_nxt = CNT_ONE;
                        w_state_nxt   = SHIFT;
                    end
                end else begin
                    w_shift       = 1'b1;
                    w_en_nxt      = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_load        = 1'b1;
                    w_en_nxt      = 1'b1;
                    w_bit_cnt_nxt = CNT_ONE;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = SHIFT;
                end else begin
                    w_clear       = 1'b1;
                    w_en_nxt      = 1'b0;
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    piso_shiftreg #(
        .WIDTH(WIDTH)
    ) u_piso (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_clear  (w_clear),
        .i_data   (w_load_word),
        .o_serial (w_serial)
    );

    assign generated_signal = w_serial;
    assign ENdin            = r_en;

endmodule

// File: tb/tb_shiftreg_pattern_top.sv
// Scoreboard bench: two generator instances (default A5/gap 2, and 81/no gap) checked every cycle.
module tb_shiftreg_pattern_top;

    logic CLK = 1'b0;
    logic RST_N;
    logic gs_a, en_a, gs_b, en_b;
    bit   mon_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] q_a[$];
    logic [1:0] q_b[$];

    // Expected {ENdin, generated_signal} per cycle of a frame, hand-derived.
    logic [1:0] tbl_a [10] = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b10,
                               2'b11, 2'b10, 2'b11, 2'b00, 2'b00};
    logic [1:0] tbl_b [8]  = '{2'b11, 2'b10, 2'b10, 2'b10,
                               2'b10, 2'b10, 2'b10, 2'b11};
    int         pos_a;
    int         pos_b;
    logic [6:0] lfsr_a;
    logic [6:0] lfsr_b;

    shiftreg_pattern_top #(
        .WIDTH      (8),
        .PATTERN    (8'hA5),
        .GAP_CYCLES (2)
    ) dut_a (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .generated_signal (gs_a),
        .ENdin            (en_a)
    );

    shiftreg_pattern_top #(
        .WIDTH      (8),
        .PATTERN    (8'h81),
        .GAP_CYCLES (0)
    ) dut_b (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .generated_signal (gs_b),
        .ENdin            (en_b)
    );

    always #31 CLK = ~CLK;

    // PRBS7 reference: x^7+x^6+1, returns {bit, next state}.
    function automatic logic [7:0] tb_prbs(input logic [6:0] s);
        logic fb;
        fb = s[6] ^ s[5];
        return {fb, s[5:0], fb};
    endfunction

    task automatic reset_model();
        pos_a  = 0;
        pos_b  = 0;
        lfsr_a = 7'h7F;
        lfsr_b = 7'h7F;
    endtask

    task automatic push_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic [1:0] ea;
            logic [1:0] eb;
            logic [7:0] st;
            ea = tbl_a[pos_a];
            eb = tbl_b[pos_b];
            pos_a = (pos_a == 9) ? 0 : pos_a + 1;
            pos_b = (pos_b == 7) ? 0 : pos_b + 1;
`ifdef SHIFTREG_PRBS_PATTERN_EN
            if (ea[1]) begin
                st     = tb_prbs(lfsr_a);
                ea[0]  = st[7];
                lfsr_a = st[6:0];
            end
            if (eb[1]) begin
                st     = tb_prbs(lfsr_b);
                eb[0]  = st[7];
                lfsr_b = st[6:0];
            end
`else
            st = '0;
`endif
            q_a.push_back(ea);
            q_b.push_back(eb);
        end
    endtask

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got en,gs=%b required %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle after reset release presents a frame bit or a gap cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            logic [1:0] e;
            if (q_a.size() == 0) begin
                check_int("dut_a scoreboard underflow", 0, 1);
            end else begin
                e = q_a.pop_front();
                check2("dut_a cycle", {en_a, gs_a}, e);
            end
            if (q_b.size() == 0) begin
                check_int("dut_b scoreboard underflow", 0, 1);
            end else begin
                e = q_b.pop_front();
                check2("dut_b cycle", {en_b, gs_b}, e);
            end
        end
    end

    initial begin
        RST_N = 1'b0;
        reset_model();

        // Reset held across two rising edges: outputs stay 0, never X.
        #20  check2("reset dut_a", {en_a, gs_a}, 2'b00);
             check2("reset dut_b", {en_b, gs_b}, 2'b00);
        #40  check2("reset dut_a", {en_a, gs_a}, 2'b00);
             check2("reset dut_b", {en_b, gs_b}, 2'b00);
        #40  check2("reset dut_a", {en_a, gs_a}, 2'b00);
             check2("reset dut_b", {en_b, gs_b}, 2'b00);

        @(negedge CLK);
        #2;
        RST_N  = 1'b1;
        mon_en = 1'b1;

        // 17 full default frames; dut_b gives 170 contiguous data bits.
        push_cycles(170);
        repeat (170) @(posedge CLK);
        @(negedge CLK);
        #1;

        // Five edges into a frame, then asynchronous reset between edges.
        push_cycles(5);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        #5;
        RST_N  = 1'b0;
        mon_en = 1'b0;
        #1;
        check2("async reset dut_a", {en_a, gs_a}, 2'b00);
        check2("async reset dut_b", {en_b, gs_b}, 2'b00);
        check_int("dut_a queue drained", q_a.size(), 0);
        check_int("dut_b queue drained", q_b.size(), 0);
        q_a.delete();
        q_b.delete();
        reset_model();

        repeat (2) @(posedge CLK);
        #1;
        check2("held reset dut_a", {en_a, gs_a}, 2'b00);
        check2("held reset dut_b", {en_b, gs_b}, 2'b00);

        @(negedge CLK);
        #2;
        RST_N  = 1'b1;
        mon_en = 1'b1;

        // Fresh frame from the MSB after release.
        push_cycles(25);
        repeat (25) @(posedge CLK);
        @(negedge CLK);
        #1;
        mon_en = 1'b0;
        check_int("dut_a final queue", q_a.size(), 0);
        check_int("dut_b final queue", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shiftreg_pattern_top.md
Name: shiftreg_pattern_top

Overview:
- Top-level serial pattern generator built around a parallel-in/serial-out shift register.
- Repeatedly shifts out a fixed WIDTH-bit word MSB-first on generated_signal.
- Asserts ENdin ("data-in enable") for exactly the cycles in which a valid bit is on generated_signal.
- Inserts GAP_CYCLES idle cycles between frames. Self-contained; no data inputs.

Parameters:
- WIDTH, 8, frame length in bits; legal range 2..32.
- PATTERN, 8'hA5, WIDTH-bit word transmitted each frame (MSB first).
- GAP_CYCLES, 2, idle cycles between frames; legal range 0..255.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RST_N  input  1  reset; asynchronous assert, active-low, applies the reset state immediately.
- generated_signal  output  1  registered serial data bit, MSB first.
- ENdin  output  1  registered enable; 1 while generated_signal carries a valid frame bit.

Behaviour:
- One clock; reset is asynchronous and active-low (CLK, RST_N); polarity and synchronicity are fixed.
- Both outputs come directly from flip-flops, with no combinational path to outputs.
- While RST_N=0: generated_signal=0, ENdin=0, shift register=0, bit counter=0, FSM=LOAD.
- FSM states and transitions:
  - LOAD (transient, one cycle)
    - First rising edge with RST_N=1 loads PATTERN.
    - Drives generated_signal=PATTERN[WIDTH-1] and ENdin=1.
    - Sets bit counter=1 and moves to SHIFT.
  - SHIFT
    - Each edge shifts left by one: generated_signal=next MSB, ENdin=1, counter++.
    - After the edge presenting bit 0 (counter==WIDTH), the next edge goes to GAP (GAP_CYCLES>0) or LOAD-equivalent (GAP_CYCLES==0).
  - GAP
    - generated_signal=0, ENdin=0 for exactly GAP_CYCLES cycles.
    - Then reload PATTERN and present its MSB with ENdin=1 on the same edge (no extra bubble).
- Timing and period:
  - The bit on output after the k-th edge of a frame (k=1..WIDTH) is PATTERN[WIDTH-k].
  - Frame period is exactly WIDTH+GAP_CYCLES clocks.
- Boundary conditions:
  - GAP_CYCLES=0: ENdin stays 1 continuously from the first edge; back-to-back frames with no idle bit.
  - Reset asserted mid-frame or mid-gap: outputs go to 0 immediately and asynchronously. After release, a fresh frame starts from the MSB on the first edge; no partial-frame resumption.
  - Shift-register bits shifted in from the LSB side are 0. generated_signal must never be X after reset.
- Counter widths:
  - Bit counter: $clog2(WIDTH+1) bits.
  - Gap counter: 8 bits.
  - No wrap beyond the defined terminal counts.

Optional Feature:
- Macro: SHIFTREG_PRBS_PATTERN_EN.
- Defined:
  - At each frame load, the register is loaded with the next WIDTH bits of a PRBS7 sequence instead of PATTERN.
  - PRBS7 polynomial is x^7+x^6+1, Fibonacci form, seed 7'h7F at reset, advancing WIDTH steps per frame.
  - First frame after reset uses seed-derived bits; the output bit is the feedback bit of each step.
  - Timing, ENdin and gap behaviour are unchanged.
- Undefined: PATTERN is loaded every frame and no LFSR logic is synthesized.

Decomposition:
- Package shiftreg_pkg:
  - FSM state enum (LOAD, SHIFT, GAP).
  - PRBS7 seed constant and tap positions.
  - Default PATTERN/WIDTH/GAP constants.
- Sub-module piso_shiftreg: parallel load, shift-left enable, serial MSB output, async active-low reset.
- The FSM, counters and optional PRBS source live in shiftreg_pattern_top.

Test Plan (defaults WIDTH=8, PATTERN=8'hA5, GAP_CYCLES=2, CLK period 62 ns unless noted):
- Hold RST_N=0 for 124 ns → generated_signal=0, ENdin=0 throughout, no X.
- Release reset, run 10 edges → edges 1–8: ENdin=1, generated_signal=1,0,1,0,0,1,0,1; edges 9–10: ENdin=0, generated_signal=0.
- Run 50 cycles → frame repeats every 10 clocks; edge 11 shows ENdin=1, generated_signal=1.
- Assert RST_N=0 asynchronously mid-frame after edge 5 → outputs 0 before next edge; after release, first edge gives MSB=1, ENdin=1.
- GAP_CYCLES=0, PATTERN=8'h81 → ENdin constantly 1, stream 1,0,0,0,0,0,0,1,1,0,… with no idle bits.
- SHIFTREG_PRBS_PATTERN_EN defined → serial stream over 127 data bits matches the PRBS7 reference model from seed 7'h7F; ENdin and gap timing identical to the default build.
